mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter and request pipeline placed directly upstream of the single-port data/instruction RAM.
- Accepts instruction-fetch reads and data-port reads and writes from the core, and serialises them onto the RAM's mem_en/mem_wr/addr/data_wr interface.
- Returns read data to the owning master with a per-port valid pulse.
- Round-robin arbitration on contention, so neither master starves.

Parameters:
- AWIDTH, 8, RAM word-address width; used for the range check.
- DWIDTH, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request; held until i_gnt
- i_addr  in  32  instruction word address
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid, one-cycle pulse
- i_rdata  out  DWIDTH  instruction read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data word address
- d_wdata  in  DWIDTH  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid, one-cycle pulse; reads only
- d_rdata  out  DWIDTH  data read data
- d_err  out  1  one-cycle pulse: out-of-range data access dropped
- mem_en  out  1  RAM enable, registered
- mem_wr  out  1  RAM write strobe, registered
- mem_addr  out  32  RAM address, registered
- mem_wdata  out  DWIDTH  RAM write data, registered
- mem_rdata  in  DWIDTH  RAM read data; combinational from mem_addr while mem_en=1

Behaviour:
- Reset is asynchronous, on rstn low. Cleared by reset:
  - all registers, mem_en, mem_wr, mem_addr, mem_wdata
  - i_rvalid, d_rvalid, d_err, rd_owner
  - rr_last = DATA, so the instruction port wins first contention.
- Reset mid-operation:
  - In-flight requests are discarded and no rvalid is issued for them.
  - Masters re-request after reset.
- Arbitration (cycle N):
  - i_gnt/d_gnt are combinational from the req inputs and rr_last. At most one is high per cycle.
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to rr_last is granted.
  - rr_last updates to the winner at the clock edge.
- Issue stage (edge N→N+1): mem_en=1, mem_wr=d_we for data or 0 for instruction, mem_addr=winner address, mem_wdata=d_wdata.
  - No grant: mem_en=0 and mem_wr=0; mem_addr/mem_wdata hold their values.
- Response stage:
  - During cycle N+1, a read samples mem_rdata into the owner's rdata register at edge N+1→N+2.
  - The owner's rvalid is high for cycle N+2 only.
  - Read latency: 2 cycles from grant to rvalid.
  - Writes complete in N+1 and produce no rvalid.
- Throughput: one grant per cycle, fully pipelined. Back-to-back reads give one rvalid per cycle, in grant order.
- i_rdata/d_rdata hold their last value when rvalid=0.
- Range check: applies when addr[31:AWIDTH] != 0.
  - Data port: the request is still granted. mem_en stays 0 in N+1. d_err pulses in N+1. No d_rvalid.
  - Instruction port: out-of-range addresses are forwarded unchecked.
- d_req with d_we=1 and d_req with d_we=0 are arbitrated identically.
- Both ports idle: no grants, mem_en=0, and rr_last is unchanged.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The data port always wins contention, and rr_last is unused and removed.
- Undefined: round-robin arbitration as described above.

Test Plan:
- Single instruction read: reset, RAM preloaded word 5 = 0xDEADBEEF; i_req, i_addr=5 at cycle 3 → i_gnt at cycle 3; mem_en=1, mem_wr=0, mem_addr=5 at cycle 4; i_rvalid and i_rdata=0xDEADBEEF at cycle 5.
- Data write then read-back: d_we=1, d_addr=0x10, d_wdata=0x12345678 → mem_wr=1 one cycle after d_gnt. Then d_we=0, d_addr=0x10 → d_rvalid with 0x12345678 two cycles after its grant.
- Contention: both req held for 4 cycles (i_addr=1, d_addr=2, reads) → grants I, D, I, D. The rvalids alternate with correct data, and there is never a double grant.
- Out of range: d_addr=0x100 with AWIDTH=8 → d_gnt, then mem_en=0 and d_err=1 next cycle, with no d_rvalid. i_addr=0x100 → forwarded, mem_addr=0x100.
- Reset mid-read: rstn low in the cycle between d_gnt and d_rvalid → d_rvalid never asserts, all outputs are 0 immediately (asynchronously), and after release the first contention grants the instruction port.
- MEM_ARB_FIXED_PRIO_EN defined, both req held for 3 cycles → d_gnt on all 3 cycles; i_gnt once d_req drops.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the core-side request/response ports and the
// RAM-side issue/read-data port of mem_arbiter.
//   slave  modport : used by mem_arbiter (takes requests and read data, drives
//                    grants, responses and the RAM command)
//   master modport : used by the environment (core + RAM model)
// Signals:
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata        instruction read port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata, d_err   data port
//   mem_en/mem_wr/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM
interface mem_arbiter_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DWIDTH-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DWIDTH-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_wr;
    logic [31:0]       mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch / data) arbiter and 2-stage
// request pipeline in front of a single-port RAM.
//   Cycle N   : combinational grant (i_gnt/d_gnt) from req inputs.
//   Cycle N+1 : registered RAM command (mem_en/mem_wr/mem_addr/mem_wdata);
//               out-of-range data accesses are dropped here and flag d_err.
//   Cycle N+2 : registered read data + one-cycle rvalid to the owning port.
// Ports: clk, rstn (async active-low), bus (mem_arbiter_if.slave).
// Build option: MEM_ARB_FIXED_PRIO_EN -> data port always wins contention
// (no round-robin state); undefined -> round-robin on contention.
module mem_arbiter #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    logic i_gnt_c;
    logic d_gnt_c;
    logic d_oor_c;

    // Issue stage registers
    logic              mem_en_q,    mem_en_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic              d_err_q,     d_err_d;
    logic              rd_pend_q,   rd_pend_d;
    port_e             rd_owner_q,  rd_owner_d;

    // Response stage registers
    logic              i_rvalid_q,  i_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic [DWIDTH-1:0] i_rdata_q,   i_rdata_d;
    logic [DWIDTH-1:0] d_rdata_q,   d_rdata_d;

    // Data address beyond the RAM's word range
    assign d_oor_c = (bus.d_addr >> AWIDTH) != 32'd0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign d_gnt_c = bus.d_req;
    assign i_gnt_c = bus.i_req & ~bus.d_req;
`else
    port_e rr_last_q, rr_last_d;

    // On contention the port that did not win last time goes first
    assign i_gnt_c = bus.i_req & (~bus.d_req | (rr_last_q == PORT_D));
    assign d_gnt_c = bus.d_req & (~bus.i_req | (rr_last_q == PORT_I));

    always_comb begin
        rr_last_d = rr_last_q;
        if (d_gnt_c) begin
            rr_last_d = PORT_D;
        end else if (i_gnt_c) begin
            rr_last_d = PORT_I;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_last_q <= PORT_D;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Next-state for issue and response stages
    always_comb begin
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_err_d     = 1'b0;
        rd_pend_d   = 1'b0;
        rd_owner_d  = rd_owner_q;

        if (i_gnt_c) begin
            mem_en_d    = 1'b1;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = bus.d_wdata;
            rd_pend_d   = 1'b1;
            rd_owner_d  = PORT_I;
        end else if (d_gnt_c) begin
            if (d_oor_c) begin
                // Granted but never reaches the RAM
                d_err_d = 1'b1;
            end else begin
                mem_en_d    = 1'b1;
                mem_wr_d    = bus.d_we;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                rd_pend_d   = ~bus.d_we;
                rd_owner_d  = PORT_D;
            end
        end

        // Read issued last cycle: capture RAM data for its owner
        i_rvalid_d = rd_pend_q & (rd_owner_q == PORT_I);
        d_rvalid_d = rd_pend_q & (rd_owner_q == PORT_D);
        i_rdata_d  = i_rvalid_d ? bus.mem_rdata : i_rdata_q;
        d_rdata_d  = d_rvalid_d ? bus.mem_rdata : d_rdata_q;
    end

    // Pipeline state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
            d_err_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= PORT_I;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_err_q     <= d_err_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.i_gnt     = i_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
